// File: rtl/reg_file_2r1w.sv
// Two-read, one-write integer register file with x0 hard-wired to zero and a0 exposed.
// Optional same-cycle write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file_2r1w #(
  parameter int Data_Width = 32,
  parameter int Addr_Width = 5,
  parameter int A0_Index   = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [Addr_Width-1:0] AD1,
  input  logic [Addr_Width-1:0] AD2,
  input  logic [Addr_Width-1:0] AD3,
  input  logic                  WE3,
  input  logic [Data_Width-1:0] WD3,
  output logic [Data_Width-1:0] RD1,
  output logic [Data_Width-1:0] RD2,
  output logic [Data_Width-1:0] a0
);

  localparam int                  Depth   = 1 << Addr_Width;
  localparam logic [Addr_Width-1:0] A0_Addr = A0_Index[Addr_Width-1:0];

  logic [Data_Width-1:0] mem [Depth];
  logic                  wr_active;

  assign wr_active = WE3 && (AD3 != '0);

  // NOTE: this storage is deliberately reset because architectural state must read 0
  // after reset; plain RAM arrays normally carry no reset so they can map to memory.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else if (wr_active) begin
      mem[AD3] <= WD3;
    end
  end

  logic [Data_Width-1:0] stored1, stored2, stored_a0;

  // Entry 0 is never written, but the explicit zero mux lets synthesis drop its flops.
  assign stored1   = (AD1 == '0) ? '0 : mem[AD1];
  assign stored2   = (AD2 == '0) ? '0 : mem[AD2];
  assign stored_a0 = mem[A0_Addr];

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    a0  = '0;
    if (rst_n) begin
`ifdef REGFILE_BYPASS_EN
      RD1 = (wr_active && AD1 == AD3)     ? WD3 : stored1;
      RD2 = (wr_active && AD2 == AD3)     ? WD3 : stored2;
      a0  = (wr_active && AD3 == A0_Addr) ? WD3 : stored_a0;
`else
      RD1 = stored1;
      RD2 = stored2;
      a0  = stored_a0;
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: directed scenarios plus randomized traffic
// compared against an array model of the architectural registers.
module tb_reg_file_2r1w;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ad1, ad2, ad3;
  logic        we3;
  logic [31:0] wd3;
  logic [31:0] rd1, rd2, a0;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [32];

  reg_file_2r1w dut (
    .clk  (clk),
    .rst_n(rst_n),
    .AD1  (ad1),
    .AD2  (ad2),
    .AD3  (ad3),
    .WE3  (we3),
    .WD3  (wd3),
    .RD1  (rd1),
    .RD2  (rd2),
    .a0   (a0)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mread(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : model[a];
  endfunction

  // Value a read port should show before the next edge, given the pending write.
  function automatic logic [31:0] mview(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
    if (rst_n && we3 && ad3 != 5'd0 && a == ad3) return wd3;
`endif
    if (!rst_n) return 32'd0;
    return mread(a);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    ad3 = a; wd3 = d; we3 = 1'b1;
    @(posedge clk);
    if (a != 5'd0) model[a] = d;
    #1;
    we3 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; we3 = 1'b0; ad3 = 5'd0; wd3 = 32'd0;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ad1 = 5'($urandom); ad2 = 5'($urandom);
      #1;
      checks++;
      if (rd1 !== 32'd0 || rd2 !== 32'd0 || a0 !== 32'd0) begin
        errors++;
        $display("FAIL reset_outputs: rd1=%h rd2=%h a0=%h required 0", rd1, rd2, a0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    do_write(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    ad1 = 5'd5;
    #1;
    checks++;
    if (rd1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL async_reset_pre: rd1=%h required deadbeef", rd1);
    end
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (rd1 !== 32'd0) begin
      errors++;
      $display("FAIL async_reset_no_edge: rd1=%h required 0", rd1);
    end
    // A write presented while reset is held must be discarded.
    @(negedge clk);
    ad3 = 5'd5; wd3 = 32'h12345678; we3 = 1'b1;
    @(posedge clk);
    #1;
    we3 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (rd1 !== 32'd0) begin
      errors++;
      $display("FAIL async_reset_after_release: rd1=%h required 0", rd1);
    end
  endtask

  task automatic test_x0();
    do_write(5'd0, 32'hFFFFFFFF);
    @(negedge clk);
    ad1 = 5'd0; ad2 = 5'd0;
    #1;
    checks++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
      errors++;
      $display("FAIL x0_write_ignored: rd1=%h rd2=%h required 0", rd1, rd2);
    end
  endtask

  task automatic test_two_ports();
    do_write(5'd3, 32'h00000007);
    do_write(5'd4, 32'hFFFFFFF9);
    @(negedge clk);
    ad1 = 5'd3; ad2 = 5'd4;
    #1;
    checks++;
    if (rd1 !== 32'h7 || rd2 !== 32'hFFFFFFF9) begin
      errors++;
      $display("FAIL two_ports: rd1=%h rd2=%h required 00000007 fffffff9", rd1, rd2);
    end
    ad2 = 5'd3;
    #1;
    checks++;
    if (rd1 !== 32'h7 || rd2 !== 32'h7) begin
      errors++;
      $display("FAIL same_address: rd1=%h rd2=%h required 00000007 both", rd1, rd2);
    end
  endtask

  task automatic test_a0();
    logic [31:0] exp_pre;
    @(negedge clk);
    ad3 = 5'd10; wd3 = 32'h0000002A; we3 = 1'b1;
`ifdef REGFILE_BYPASS_EN
    exp_pre = 32'h2A;
`else
    exp_pre = 32'h0;
`endif
    #1;
    checks++;
    if (a0 !== exp_pre) begin
      errors++;
      $display("FAIL a0_before_edge: a0=%h required %h", a0, exp_pre);
    end
    @(posedge clk);
    model[10] = 32'h2A;
    #1;
    we3 = 1'b0;
    checks++;
    if (a0 !== 32'h2A) begin
      errors++;
      $display("FAIL a0_after_edge: a0=%h required 0000002a", a0);
    end
  endtask

  task automatic test_collision();
    logic [31:0] exp_pre;
    do_write(5'd6, 32'h11);
    @(negedge clk);
    ad2 = 5'd6; ad3 = 5'd6; wd3 = 32'h22; we3 = 1'b1;
`ifdef REGFILE_BYPASS_EN
    exp_pre = 32'h22;
`else
    exp_pre = 32'h11;
`endif
    #1;
    checks++;
    if (rd2 !== exp_pre) begin
      errors++;
      $display("FAIL collision_before_edge: rd2=%h required %h", rd2, exp_pre);
    end
    @(posedge clk);
    model[6] = 32'h22;
    #1;
    we3 = 1'b0;
    checks++;
    if (rd2 !== 32'h22) begin
      errors++;
      $display("FAIL collision_after_edge: rd2=%h required 00000022", rd2);
    end
  endtask

  task automatic test_walking();
    for (int i = 1; i < 32; i++) do_write(5'(i), i * 32'h01010101);
    for (int k = 0; k < 32; k++) begin
      logic [31:0] e1, e2;
      @(negedge clk);
      ad1 = 5'(k); ad2 = 5'(31 - k);
      e1 = 32'(k) * 32'h01010101;
      e2 = 32'(31 - k) * 32'h01010101;
      #1;
      checks++;
      if (rd1 !== e1 || rd2 !== e2) begin
        errors++;
        $display("FAIL walking[%0d]: rd1=%h rd2=%h required %h %h", k, rd1, rd2, e1, e2);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic [31:0] e1, e2, ea;
      @(negedge clk);
      ad1 = 5'($urandom); ad2 = 5'($urandom);
      ad3 = ($urandom_range(0, 3) == 0) ? ad1 : 5'($urandom);
      we3 = 1'($urandom); wd3 = $urandom;
      e1 = mview(ad1); e2 = mview(ad2); ea = mview(5'd10);
      #1;
      checks++;
      if (rd1 !== e1 || rd2 !== e2 || a0 !== ea) begin
        errors++;
        $display("FAIL random_pre[%0d]: rd1=%h rd2=%h a0=%h required %h %h %h",
                 n, rd1, rd2, a0, e1, e2, ea);
      end
      @(posedge clk);
      if (we3 && ad3 != 5'd0) model[ad3] = wd3;
      #1;
      we3 = 1'b0;
      e1 = mread(ad1); e2 = mread(ad2); ea = mread(5'd10);
      #1;
      checks++;
      if (rd1 !== e1 || rd2 !== e2 || a0 !== ea) begin
        errors++;
        $display("FAIL random_post[%0d]: rd1=%h rd2=%h a0=%h required %h %h %h",
                 n, rd1, rd2, a0, e1, e2, ea);
      end
    end
  endtask

  initial begin
    ad1 = 5'd0; ad2 = 5'd0;
    test_reset();
    test_async_reset();
    test_x0();
    test_two_ports();
    test_a0();
    test_collision();
    test_walking();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
